// File: rtl/sram_avalon_ctrl.sv
// Avalon-MM slave driving an asynchronous SRAM. Reads return through readdatavalid.
// Every SRAM-facing output is a flop, so the strobes stay glitch-free.
module sram_avalon_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 20,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1,
    parameter int TURN    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   avs_address,
    input  logic [DATA_W/8-1:0] avs_byteenable,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [DATA_W-1:0]   avs_writedata,
    output logic [DATA_W-1:0]   avs_readdata,
    output logic                avs_readdatavalid,
    output logic                avs_waitrequest,
    inout  wire  [DATA_W-1:0]   sram_DQ,
    output logic [ADDR_W-1:0]   sram_ADDR,
    output logic [DATA_W/8-1:0] sram_BE_N,
    output logic                sram_CE_N,
    output logic                sram_OE_N,
    output logic                sram_WE_N
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [2:0] {S_IDLE, S_TURN, S_RD, S_WSETUP, S_WPULSE, S_WHOLD} state_e;

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                last_rd_q, last_rd_d;
    logic                wait_q, wait_d;
    logic                rdv_q, rdv_d;
    logic                ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic [BE_W-1:0]     be_n_q, be_n_d;
    logic                dq_oe_q, dq_oe_d;
    logic                accept, wr_ph;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        last_rd_d = last_rd_q;
        rdata_d   = rdata_q;
        rdv_d     = 1'b0;
        accept    = (avs_read | avs_write) && !wait_q;

        case (state_q)
            S_IDLE: if (accept) begin
                addr_d  = avs_address;
                be_d    = avs_byteenable;
                wdata_d = avs_writedata;
                // A read and a write offered together: the read is served and the write is dropped.
                if (avs_read) begin
                    state_d   = S_RD;
                    cnt_d     = 3'(RD_WAIT);
                    last_rd_d = 1'b1;
                end else begin
                    last_rd_d = 1'b0;
                    if (last_rd_q && (TURN > 0)) begin
                        state_d = S_TURN;
                        cnt_d   = 3'(TURN - 1);
                    end else begin
                        state_d = S_WSETUP;
                    end
                end
            end
            S_TURN: begin
                if (cnt_q == 3'd0) state_d = S_WSETUP;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_RD: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_IDLE;
                    rdata_d = sram_DQ;
                    rdv_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_WSETUP: begin
                state_d = S_WPULSE;
                cnt_d   = 3'(WR_WAIT);
            end
            S_WPULSE: begin
                if (cnt_q == 3'd0) state_d = S_WHOLD;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_WHOLD: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // SRAM strobes are decoded from the next state so the flops present them during that state.
        wr_ph   = (state_d == S_WSETUP) || (state_d == S_WPULSE) || (state_d == S_WHOLD);
        ce_n_d  = !(wr_ph || (state_d == S_RD));
        oe_n_d  = (state_d != S_RD);
        we_n_d  = (state_d != S_WPULSE);
        dq_oe_d = wr_ph;
        wait_d  = (state_d != S_IDLE);
        if (state_d == S_RD) be_n_d = '0;
        else if (wr_ph)      be_n_d = ~be_d;
        else                 be_n_d = '1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            last_rd_q <= 1'b0;
            wait_q    <= 1'b1;
            rdv_q     <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            be_n_q    <= '1;
            dq_oe_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            last_rd_q <= last_rd_d;
            wait_q    <= wait_d;
            rdv_q     <= rdv_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            be_n_q    <= be_n_d;
            dq_oe_q   <= dq_oe_d;
        end
    end

    assign sram_DQ           = dq_oe_q ? wdata_q : 'z;
    assign sram_ADDR         = addr_q;
    assign sram_BE_N         = be_n_q;
    assign sram_CE_N         = ce_n_q;
    assign sram_OE_N         = oe_n_q;
    assign sram_WE_N         = we_n_q;
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rdv_q;
    assign avs_waitrequest   = wait_q;

endmodule
